// File: rtl/uart_word_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_deserializer_pkg
// Description : Shared UART definitions: byte width, default clock/baud, the
//               inter-byte timeout derivation and the assembler state type.
//               Also used by uart_tx / uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_word_deserializer_pkg;

    localparam int BYTE_W     = 8;
    localparam int CLOCK_FREQ = 125_000_000;
    localparam int BAUD_RATE  = 115_200;

    // Two byte times (10 bits per frame) expressed in clocks. The bit period
    // is rounded to whole clocks first, matching the UART bit divider.
    function automatic int timeout_cycles_for(input int clk_hz, input int baud);
        return 20 * (clk_hz / baud);
    endfunction

    localparam int DEFAULT_TIMEOUT_CYCLES = timeout_cycles_for(CLOCK_FREQ, BAUD_RATE);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } asm_state_t;

endpackage : uart_word_deserializer_pkg
`default_nettype wire

// File: rtl/uart_word_deserializer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_deserializer_sync_fifo
// Description : Single-clock FIFO with first-word fall-through read data.
//               A push into a full FIFO is accepted when a pop happens on the
//               same edge. Full/empty come from the occupancy count, so the
//               pointers simply wrap.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               push, wdata       - write request and data
//               pop               - read request (ignored when empty)
//               rdata             - head-of-FIFO data
//               full, empty,count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_deserializer_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    // When full, the slot being written is the head being popped this edge.
    assign w_push_ok = push && (!full || w_pop_ok);

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_word_deserializer_sync_fifo
`default_nettype wire

// File: rtl/uart_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_deserializer
// Description : Packs the UART receive byte stream into little-endian words
//               and queues them in a FIFO with a valid/ready output. Drives
//               local_ready (RTS) low while the FIFO is near full and drops
//               partial words that stall longer than TIMEOUT_CYCLES.
// Ports       : clock, reset                 - clock, sync active-high reset
//               byte_in, byte_in_valid       - received byte strobe
//               local_ready                  - 1 = room for more bytes
//               word_out, word_out_valid,
//               word_out_ready               - output word handshake
//               fill_level                   - words stored
//               overflow, timeout_err        - sticky error flags
//               clear_errors                 - clears both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_deserializer
    import uart_word_deserializer_pkg::*;
#(
    parameter int WORD_BYTES     = 4,
    parameter int DEPTH          = 8,
    parameter int SLACK_WORDS    = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [BYTE_W-1:0]            byte_in,
    input  logic                         byte_in_valid,
    output logic                         local_ready,
    output logic [BYTE_W*WORD_BYTES-1:0] word_out,
    output logic                         word_out_valid,
    input  logic                         word_out_ready,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic                         overflow,
    output logic                         timeout_err,
    input  logic                         clear_errors
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int ACC_W  = BYTE_W * (WORD_BYTES - 1);
    localparam int BC_W   = $clog2(WORD_BYTES);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    asm_state_t        r_state;
    asm_state_t        w_state_next;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic              r_overflow;
    logic              r_timeout_err;
    logic              r_local_ready;

    logic              w_byte_last;
    logic              w_expire;
    logic              w_timeout_evt;
    logic              w_pop;
    logic              w_push;
    logic              w_overflow_evt;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [WORD_W-1:0] w_word;

    assign w_byte_last = byte_in_valid && (r_byte_cnt == BC_W'(WORD_BYTES - 1));
    // The final byte goes straight into the top lane; earlier bytes sit in r_acc.
    assign w_word      = {byte_in, r_acc};

    // Fires on the edge where idle_cnt would reach TIMEOUT_CYCLES; a byte on
    // that same edge takes priority.
    assign w_expire      = (TIMEOUT_CYCLES != 0) && (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout_evt = (r_state == ST_COLLECT) && !byte_in_valid && w_expire;

    assign word_out_valid = !w_fifo_empty;
    assign w_pop          = word_out_valid && word_out_ready;
    assign w_push         = w_byte_last && (!w_fifo_full || w_pop);
    assign w_overflow_evt = w_byte_last && w_fifo_full && !w_pop;
    assign w_count_next   = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign fill_level  = w_count;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign local_ready = r_local_ready;

    uart_word_deserializer_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .wdata (w_word),
        .pop   (w_pop),
        .rdata (word_out),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (byte_in_valid) begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_byte_last || w_timeout_evt) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (byte_in_valid) begin
                r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + 1'b1;
                r_idle_cnt <= '0;
            end else if (w_timeout_evt) begin
                r_byte_cnt <= '0;
                r_idle_cnt <= '0;
            end else if (r_state == ST_COLLECT) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    // Lane contents need no reset: byte_cnt restarts at 0 and rewrites every
    // lane before a word is pushed.
    always_ff @(posedge clock) begin
        if (byte_in_valid && !w_byte_last) begin
            r_acc[BYTE_W*r_byte_cnt +: BYTE_W] <= byte_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_local_ready <= 1'b0;
        end else begin
            r_overflow    <= w_overflow_evt || (r_overflow    && !clear_errors);
            r_timeout_err <= w_timeout_evt  || (r_timeout_err && !clear_errors);
            r_local_ready <= (w_count_next < CNT_W'(DEPTH - SLACK_WORDS));
        end
    end

endmodule : uart_word_deserializer
`default_nettype wire
